// File: rtl/histeq_pkg.sv
// Shared histogram-equalisation constants and state encoding.
// Used by the CDF accumulator and the scaled-histogram stage.
package histeq_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IN_WIDTH   = $clog2(640 * 480);
  localparam int NUM_LEVELS = 2 ** DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CDF   = 2'd1,
    ST_DONE  = 2'd2
  } cdf_state_e;

endpackage

// File: rtl/cdf_accumulator.sv
// Frame histogram accumulation followed by a one-bin-per-cycle
// cumulative pass; bins are cleared as they are read.
module cdf_accumulator
  import histeq_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int inWidth      = IN_WIDTH,
  parameter int numIntLevels = 2 ** DataWidth
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_pixel_valid,
  input  logic [DataWidth-1:0]            i_pixel,
  input  logic                            i_pixel_last,
  output logic                            o_pixel_ready,
  output logic [inWidth*numIntLevels-1:0] o_cdf,
  output logic [inWidth-1:0]              o_cdfMin,
  output logic                            o_cdf_done
);

  localparam int IdxW = (numIntLevels > 1) ? $clog2(numIntLevels) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(numIntLevels - 1);

  cdf_state_e state_q, state_d;

  logic [inWidth-1:0] bin_q [numIntLevels];
  logic [IdxW-1:0]    idx_q;
  logic [inWidth-1:0] sum_q;
  logic               found_q;
  logic [inWidth*numIntLevels-1:0] cdf_q;
  logic [inWidth-1:0] cdfmin_q;

  logic               accept;
  logic [inWidth-1:0] bin_rd;
  logic [inWidth:0]   sum_wide;
  logic [inWidth-1:0] sum_upd;

  assign accept = i_pixel_valid && o_pixel_ready;
  assign bin_rd = bin_q[idx_q];

  // running sum including the bin under the index, clamped at full scale
  always_comb begin
    sum_wide = {1'b0, sum_q} + {1'b0, bin_rd};
    sum_upd  = sum_wide[inWidth] ? '1 : sum_wide[inWidth-1:0];
  end

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_ACCUM;
    else            state_q <= state_d;
  end

  // next state and handshake/strobe outputs
  always_comb begin
    state_d       = state_q;
    o_pixel_ready = 1'b0;
    o_cdf_done    = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        o_pixel_ready = 1'b1;
        if (i_pixel_valid && i_pixel_last) state_d = ST_CDF;
      end
      ST_CDF: begin
        if (idx_q == IdxLast) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_cdf_done = 1'b1;
        state_d    = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // histogram bins: count accepted pixels, clear each bin as the pass reads it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < numIntLevels; k++) bin_q[k] <= '0;
    end else if (accept) begin
      if (bin_q[i_pixel] != '1)
        bin_q[i_pixel] <= bin_q[i_pixel] + inWidth'(1);
    end else if (state_q == ST_CDF) begin
      bin_q[idx_q] <= '0;
    end
  end

  // cumulative pass: index walk, running sum, output slots and minimum
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q    <= '0;
      sum_q    <= '0;
      found_q  <= 1'b0;
      cdf_q    <= '0;
      cdfmin_q <= '0;
    end else if (state_q == ST_CDF) begin
      idx_q <= idx_q + IdxW'(1);
      sum_q <= sum_upd;
      cdf_q[idx_q*inWidth +: inWidth] <= sum_upd;
      if (!found_q && sum_upd != '0) begin
        found_q  <= 1'b1;
        cdfmin_q <= sum_upd;
      end
    end else begin
      idx_q   <= '0;
      sum_q   <= '0;
      found_q <= 1'b0;
    end
  end

  assign o_cdf    = cdf_q;
  assign o_cdfMin = cdfmin_q;

endmodule

// File: doc/cdf_accumulator.md
CDF_ACCUMULATOR -- requirements
Module: cdf_accumulator

Interface
REQ-001 Parameter DataWidth, default 8, pixel intensity width.
REQ-002 Parameter inWidth, default $clog2(640*480), width of each bin count, cumulative value and cdfMin.
REQ-003 Parameter numIntLevels, default 2**DataWidth, number of histogram bins.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_pixel_valid  input  1  pixel present on i_pixel.
REQ-007 i_pixel  input  DataWidth  pixel intensity.
REQ-008 i_pixel_last  input  1  qualifies the final pixel of a frame.
REQ-009 o_pixel_ready  output  1  block accepts a pixel this cycle.
REQ-010 o_cdf  output  inWidth*numIntLevels  flat cumulative histogram; bin k at [k*inWidth +: inWidth].
REQ-011 o_cdfMin  output  inWidth  first non-zero cumulative value of the last frame.
REQ-012 o_cdf_done  output  1  one-cycle pulse: o_cdf/o_cdfMin valid; drives downstream start_calc.

Function
REQ-013 States ACCUM, CDF and DONE; reset state ACCUM.
REQ-014 ACCUM: o_pixel_ready=1; a pixel is accepted on a cycle with i_pixel_valid && o_pixel_ready.
REQ-015 Accepted pixel p increments bin[p] by 1, saturating at 2**inWidth-1.
REQ-016 Accepted pixel with i_pixel_last=1 is counted, then the state moves to CDF with index 0 on the next cycle.
REQ-017 CDF and DONE: o_pixel_ready=0; i_pixel_valid/i_pixel/i_pixel_last ignored; no bin changes except REQ-019.
REQ-018 CDF: one bin per cycle, index 0..numIntLevels-1; running sum S += bin[index], saturating at 2**inWidth-1; o_cdf slot[index] <= updated S.
REQ-019 CDF: bin[index] is cleared to 0 in the same cycle it is read, so the next frame starts from zero.
REQ-020 o_cdfMin <= updated S at the first index where updated S != 0 during this CDF pass; S is reset to 0 at CDF entry.
REQ-021 After index numIntLevels-1: DONE for exactly one cycle with o_cdf_done=1, then ACCUM.
REQ-022 Latency: last pixel accepted at cycle T -> o_cdf_done high at cycle T+numIntLevels+1 (T+257 default).
REQ-023 o_cdf and o_cdfMin hold their values from DONE until overwritten slot-by-slot in the next CDF pass.
REQ-024 o_cdfMin is never 0 after a frame, because the last pixel is always counted.
REQ-025 Single-pixel frame (valid && last on first accepted pixel) is legal; full CDF pass follows.

Reset
REQ-026 Asserting i_reset_n low, at any time, clears immediately: state=ACCUM, all bins=0, S=0, index=0, o_cdf=0, o_cdfMin=0, o_cdf_done=0.
REQ-027 o_pixel_ready=1 while in reset-released ACCUM; a reset during CDF abandons the frame, with no o_cdf_done pulse.

Structure
REQ-028 Shared package histeq_pkg holds DATA_WIDTH, IN_WIDTH, NUM_LEVELS and the state encoding, shared with scaled-histogram stage.
REQ-029 Single module, no sub-modules; bins are a register array, since all bins are cleared within one pass.

Verification
REQ-030 Reset then 4 pixels {3,3,7,255 last} -> after 257 cycles: o_cdf slots 0-2=0, 3-6=2, 7-254=3, 255=4; o_cdfMin=2; o_cdf_done pulse width 1.
REQ-031 640*480 pixels all value 0, last on final -> every slot=307200; o_cdfMin=307200; done at T+257.
REQ-032 Valid held high during CDF/DONE -> o_pixel_ready=0, no pixel counted; a second frame {5 last} then gives slot 5..255=1, slots 0-4=0, o_cdfMin=1 (bins cleared).
REQ-033 Reset asserted at CDF index 100 -> all outputs 0 immediately, no done pulse; next frame {0 last} -> all slots 1, o_cdfMin=1.
REQ-034 Frame of 2**inWidth+5 pixels of value 9 -> bin and slots 9..255 saturate at 2**inWidth-1; o_cdfMin=2**inWidth-1.
REQ-035 Valid gaps: pixels {1,_,2,_,_,1 last} with valid low in gaps -> slot 1=2, slot 2..255=3, o_cdfMin=2.
